// File: rtl/uart_pkg.sv
// Shared definitions for the serial receive path: field widths, framing bit
// levels and the receiver state encoding.
package uart_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int BAUD_W  = 20;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_WAIT_HI = 3'd4
  } state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to
// the idle (high) level so no false start edge is seen after reset.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_ten_eight.sv
// 10-bit frame to 8-bit byte serial receiver (start, 8 data LSB first, stop)
// with programmable bit period latched at the start edge.
module rx_ten_eight
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [BAUD_W-1:0] baud,
  input  logic              rx_in,
  output logic [DATA_W-1:0] dout,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              frame_err,
  output logic [FRAME_W-1:0] rx_d
);

  // state      | meaning
  // IDLE       | waiting for a falling edge on the synchronized line
  // START      | half a bit period in, confirm the start bit is still low
  // DATA       | one sample per bit period, 8 data bits LSB first
  // STOP       | sample the stop bit, publish byte or flag framing error
  // WAIT_HI    | line held low after a bad stop bit, wait for it to rise

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   cnt, cnt_nxt;
  logic [BAUD_W-1:0]   bper, bper_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   dout_nxt;
  logic [FRAME_W-1:0]  rx_d_nxt;
  logic                valid_nxt, err_nxt;
  logic                rx_s, rx_s_q;
  logic                fall, baud_ok;
  logic [BAUD_W-1:0]   half_m1, bper_m1;

  rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  assign fall    = rx_s_q & ~rx_s;
  assign baud_ok = (baud >= BAUD_W'(2));
  assign half_m1 = (bper >> 1) - BAUD_W'(1);
  assign bper_m1 = bper - BAUD_W'(1);
  assign rx_busy = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bper_nxt    = bper;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    dout_nxt    = dout;
    rx_d_nxt    = rx_d;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (sel && baud_ok && fall) begin
          state_nxt   = ST_START;
          bper_nxt    = baud;
          cnt_nxt     = '0;
          bit_cnt_nxt = '0;
        end
      end
      ST_START: begin
        cnt_nxt = cnt + BAUD_W'(1);
        if (cnt == half_m1) begin
          cnt_nxt   = '0;
          state_nxt = (rx_s == START_BIT) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        cnt_nxt = cnt + BAUD_W'(1);
        if (cnt == bper_m1) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_s, shreg[DATA_W-1:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_nxt = cnt + BAUD_W'(1);
        if (cnt == bper_m1) begin
          cnt_nxt  = '0;
          rx_d_nxt = {rx_s, shreg, START_BIT};
          if (rx_s == STOP_BIT) begin
            dout_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Losing the enable abandons the frame silently, even on the stop sample.
    if (state != ST_IDLE && !sel) begin
      state_nxt = ST_IDLE;
      dout_nxt  = dout;
      rx_d_nxt  = rx_d;
      valid_nxt = 1'b0;
      err_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bper      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_s_q    <= 1'b1;
      dout      <= '0;
      rx_d      <= '1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bper      <= bper_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      rx_s_q    <= rx_s;
      dout      <= dout_nxt;
      rx_d      <= rx_d_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= err_nxt;
    end
  end

endmodule
